// File: rtl/onehot_pkg.sv
// Shared constants, scheduler state encoding and index/one-hot helper
// for the onehot benchmark group.
package onehot_pkg;

    localparam int unsigned NREQ  = 16;
    localparam int unsigned IDX_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sched_state_t;

    function automatic logic [NREQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
        logic [NREQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner selection: lowest set request at or
// above ptr, falling back to the lowest set request overall.
module rr_pick
    import onehot_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] win_idx,
    output logic [NREQ-1:0]  win_onehot
);

    logic [NREQ-1:0]  masked;
    logic             hit_hi;
    logic             hit_all;
    logic [IDX_W-1:0] idx_hi;
    logic [IDX_W-1:0] idx_all;

    always_comb begin
        masked  = '0;
        hit_hi  = 1'b0;
        hit_all = 1'b0;
        idx_hi  = '0;
        idx_all = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            masked[i] = req[i] && (IDX_W'(i) >= ptr);
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!hit_hi && masked[i]) begin
                hit_hi = 1'b1;
                idx_hi = IDX_W'(i);
            end
            if (!hit_all && req[i]) begin
                hit_all = 1'b1;
                idx_all = IDX_W'(i);
            end
        end
    end

    // The masked pass wins whenever anything at or above ptr is requesting.
    assign any        = hit_all;
    assign win_idx    = hit_hi ? idx_hi : idx_all;
    assign win_onehot = hit_all ? idx2onehot(win_idx) : '0;

endmodule

// File: rtl/onehot_rr_sched.sv
// Round-robin scheduler over 16 requesters with registered one-hot grant,
// binary index, valid flag and hold-limit timeout pulse.
module onehot_rr_sched
    import onehot_pkg::*;
#(
    parameter int unsigned NREQ     = 16,
    parameter int unsigned IDX_W    = 4,
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             timeout
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    sched_state_t     state;
    logic [IDX_W-1:0] ptr;
    logic [7:0]       hold_cnt;

    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;
    logic [NREQ-1:0]  pick_onehot;

    rr_pick u_pick (
        .req        (req),
        .ptr        (ptr),
        .any        (pick_any),
        .win_idx    (pick_idx),
        .win_onehot (pick_onehot)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            hold_cnt    <= '0;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && pick_any) begin
                        grant       <= pick_onehot;
                        grant_idx   <= pick_idx;
                        grant_valid <= 1'b1;
                        hold_cnt    <= '0;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    // Request drop outranks expiry, so no timeout when both coincide.
                    if (!enable || !req[grant_idx] || hold_cnt == HOLD_LAST) begin
                        grant       <= '0;
                        grant_idx   <= '0;
                        grant_valid <= 1'b0;
                        ptr         <= grant_idx + 1'b1;
                        state       <= IDLE;
                        timeout     <= enable && req[grant_idx];
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_onehot_rr_sched.sv
// Self-checking bench for onehot_rr_sched: per-cycle reference model feeds
// an expectation queue, plus directed checks on grant order and pointer.
module tb_onehot_rr_sched;

    localparam int unsigned HOLD = 8;

    typedef struct {
        logic [15:0] g;
        logic [3:0]  i;
        logic        v;
        logic        t;
        logic [3:0]  p;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] req = '0;
    logic [15:0] grant;
    logic [3:0]  grant_idx;
    logic        grant_valid;
    logic        timeout;

    int total = 0;
    int bad = 0;

    exp_t     sb[$];
    int       wins[$];
    int       tcount = 0;
    logic     prev_valid = 1'b0;

    // reference model state
    logic       m_busy = 1'b0;
    logic [3:0] m_own = '0;
    logic [3:0] m_ptr = '0;
    int         m_cnt = 0;

    onehot_rr_sched #(
        .NREQ     (16),
        .IDX_W    (4),
        .HOLD_MAX (HOLD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .req         (req),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        exp_t       e;
        logic       found;
        logic [3:0] c;
        e.t = 1'b0;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_ptr  = '0;
            m_own  = '0;
            m_cnt  = 0;
        end else if (!m_busy) begin
            found = 1'b0;
            for (int k = 0; k < 16; k++) begin
                c = m_ptr + 4'(k);
                if (!found && enable && req[c]) begin
                    found  = 1'b1;
                    m_busy = 1'b1;
                    m_own  = c;
                    m_cnt  = 0;
                end
            end
        end else begin
            if (!enable || !req[m_own] || m_cnt == int'(HOLD) - 1) begin
                e.t    = enable && req[m_own];
                m_busy = 1'b0;
                m_ptr  = m_own + 4'd1;
            end else begin
                m_cnt++;
            end
        end
        e.g = m_busy ? (16'h0001 << m_own) : 16'h0000;
        e.i = m_busy ? m_own : 4'd0;
        e.v = m_busy;
        e.p = m_ptr;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        model_edge();
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("grant", 32'(grant), 32'(e.g));
            check("grant_idx", 32'(grant_idx), 32'(e.i));
            check("grant_valid", 32'(grant_valid), 32'(e.v));
            check("timeout", 32'(timeout), 32'(e.t));
            check("ptr", 32'(dut.ptr), 32'(e.p));
        end
        if (grant_valid === 1'b1 && prev_valid !== 1'b1) wins.push_back(int'(grant_idx));
        if (timeout === 1'b1) tcount++;
        prev_valid = grant_valid;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset held with all requests asserted
        enable = 1'b1;
        req    = 16'hFFFF;
        rst_n  = 1'b0;
        tick();
        tick();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_valid", 32'(grant_valid), 32'h0);
        rst_n = 1'b1;
        tick();
        check("first_grant", 32'(grant), 32'h0001);
        check("first_idx", 32'(grant_idx), 32'h0);

        // Fairness sweep
        do_reset();
        req = 16'h8005;
        wins.delete();
        tcount = 0;
        repeat (36) tick();
        check("fair_nwins", 32'(wins.size()), 32'd4);
        check("fair_w0", 32'(wins[0]), 32'd0);
        check("fair_w1", 32'(wins[1]), 32'd2);
        check("fair_w2", 32'(wins[2]), 32'd15);
        check("fair_w3", 32'(wins[3]), 32'd0);
        check("fair_timeouts", 32'(tcount), 32'd4);

        // Wrap from pointer 15
        do_reset();
        req = 16'h4000;
        tick();
        req = 16'h0000;
        tick();
        check("wrap_ptr15", 32'(dut.ptr), 32'd15);
        req = 16'h0003;
        wins.delete();
        repeat (10) tick();
        check("wrap_nwins", 32'(wins.size()), 32'd2);
        check("wrap_w0", 32'(wins[0]), 32'd0);
        check("wrap_w1", 32'(wins[1]), 32'd1);

        // Early release by owner
        do_reset();
        req = 16'h0010;
        tick();
        check("early_idx", 32'(grant_idx), 32'd4);
        tick();
        tick();
        req = 16'h0000;
        tick();
        check("early_grant", 32'(grant), 32'h0);
        check("early_timeout", 32'(timeout), 32'h0);
        check("early_ptr", 32'(dut.ptr), 32'd5);

        // Enable drop mid-grant
        do_reset();
        req = 16'h0200;
        tick();
        tick();
        enable = 1'b0;
        tick();
        check("en_grant", 32'(grant), 32'h0);
        check("en_ptr", 32'(dut.ptr), 32'd10);
        tick();
        enable = 1'b1;
        tick();
        check("reen_idx", 32'(grant_idx), 32'd9);
        check("reen_grant", 32'(grant), 32'h0200);

        // Request drop coincides with hold expiry
        do_reset();
        req = 16'h0008;
        tick();
        repeat (HOLD - 1) tick();
        req = 16'h0000;
        tick();
        check("sim_timeout", 32'(timeout), 32'h0);
        check("sim_grant", 32'(grant), 32'h0);

        // Randomised traffic with occasional enable drops and resets
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 5) == 0) req = 16'($urandom);
            if ($urandom_range(0, 9) == 0) req = 16'h0000;
            enable = ($urandom_range(0, 11) != 0);
            rst_n  = ($urandom_range(0, 59) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
